// File: rtl/seq_divider_pkg.sv
// Shared ALU divider definitions: state encoding, default width, div-by-zero constant.
package seq_divider_pkg;

  // Default operand width of the ALU datapath
  localparam int unsigned DIV_N = 8;

  // Iteration counter width for the default operand width
  localparam int unsigned DIV_CNT_W = $clog2(DIV_N);

  // Quotient reported for a zero divisor at the default width (all ones)
  localparam logic [DIV_N-1:0] DIV0_QUOTIENT = '1;

  // Divider control states
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  // Counter width for an arbitrary operand width (at least one bit)
  function automatic int unsigned div_cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage : seq_divider_pkg

// File: rtl/seq_divider_add_sub.sv
// Generic W-bit adder/subtractor: s = a + b (addn_sub=0) or a - b (addn_sub=1).
module add_sub #(
  parameter int unsigned W = 9
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         addn_sub,
  output logic [W-1:0] s,
  output logic         cout
);

  logic [W-1:0] b_eff;
  logic [W:0]   sum;

  // Two's-complement subtract by inverting b and injecting a carry of one
  always_comb begin
    b_eff = b ^ {W{addn_sub}};
    sum   = {1'b0, a} + {1'b0, b_eff} + (W + 1)'(addn_sub);
    s     = sum[W-1:0];
    cout  = sum[W];
  end

endmodule : add_sub

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one trial subtraction per clock.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned N = DIV_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int unsigned CNT_W = div_cnt_width(N);
  localparam logic [N-1:0] QUO_DIV0 = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  div_state_t state;
  logic [CNT_W-1:0] cnt;
  logic [N-1:0] work_q;
  // Partial remainder between iterations is always below the divisor, so its
  // (N+1)th bit is zero and only the low N bits are stored.
  logic [N-1:0] part_rem;
  logic [N-1:0] dvs;

  logic [N:0]   shift_rem;
  logic [N:0]   trial;
  logic         trial_cout_unused;
  logic [N-1:0] rem_next;
  logic [N-1:0] q_next;

  // Shift {remainder, quotient} left and form this iteration's results
  always_comb begin
    shift_rem = {part_rem, work_q[N-1]};
    rem_next  = trial[N] ? shift_rem[N-1:0] : trial[N-1:0];
    q_next    = {work_q[N-2:0], ~trial[N]};
  end

  // Trial subtraction of the latched divisor from the shifted remainder
  add_sub #(
    .W (N + 1)
  ) u_trial (
    .a        (shift_rem),
    .b        ({1'b0, dvs}),
    .addn_sub (1'b1),
    .s        (trial),
    .cout     (trial_cout_unused)
  );

  // Control FSM, working registers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= DIV_IDLE;
      cnt         <= '0;
      work_q      <= '0;
      part_rem    <= '0;
      dvs         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            if (divisor == '0) begin
              // Zero divisor completes immediately without iterating
              state       <= DIV_DONE;
              done        <= 1'b1;
              quotient    <= QUO_DIV0;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state    <= DIV_RUN;
              busy     <= 1'b1;
              work_q   <= dividend;
              part_rem <= '0;
              dvs      <= divisor;
              cnt      <= '0;
            end
          end
        end

        DIV_RUN: begin
          work_q   <= q_next;
          part_rem <= rem_next;
          cnt      <= CNT_W'(cnt + CNT_W'(1));
          if (cnt == CNT_LAST) begin
            state       <= DIV_DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            quotient    <= q_next;
            remainder   <= rem_next;
            div_by_zero <= 1'b0;
          end
        end

        DIV_DONE: begin
          // Single-cycle completion pulse; start is not sampled here
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= DIV_IDLE;
        end

        default: begin
          state <= DIV_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule : seq_divider
